// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT byte buffer behind uart_rx: one write per rx_done rising edge,
// read-enable pop, sticky overrun when a byte is dropped on a full FIFO.
module uart_rx_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_done,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overrun,
  input  logic                  clr_overrun
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam int unsigned PW    = DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;

  logic                  rx_done_q;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic wr_req;
  logic do_wr;
  logic do_rd;
  logic drop;

  // A full FIFO is never empty, so rd_en on a full cycle always frees a slot.
  assign wr_req = rx_done & ~rx_done_q;
  assign do_rd  = rd_en & ~empty;
  assign do_wr  = wr_req & (~full | rd_en);
  assign drop   = wr_req & full & ~rd_en;

  assign empty   = (count == CW'(0));
  assign full    = (count == CW'(DEPTH));
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // rx_done_q resets high so a level held through reset release is not a write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_done_q <= 1'b1;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overrun   <= 1'b0;
    end else begin
      rx_done_q <= rx_done;
      if (do_wr) wr_ptr <= wr_ptr + PW'(1);
      if (do_rd) rd_ptr <= rd_ptr + PW'(1);
      unique case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (drop) overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
    end
  end

  // Storage array, deliberately left unreset.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= rx_data;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: expected bytes queued on write, checked on FWFT head.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overrun;
  logic       clr_overrun;

  int         vec = 0;
  int         err = 0;
  logic [7:0] q[$];
  logic       mov;
  logic [7:0] hd;

  uart_rx_fifo #(.DATA_WIDTH(8), .DEPTH_LOG2(4)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done), .rd_en(rd_en),
    .rd_data(rd_data), .empty(empty), .full(full), .count(count),
    .overrun(overrun), .clr_overrun(clr_overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, required finish before 2ms");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string name);
    hd = (q.size() != 0) ? q[0] : 8'h00;
    vec++;
    if ({count, empty, full, overrun} !== {5'(q.size()), q.size() == 0, q.size() == 16, mov}) begin
      err++;
      $display("FAIL %s status: got count=%0d empty=%b full=%b ovr=%b, required count=%0d empty=%b full=%b ovr=%b",
               name, count, empty, full, overrun, q.size(), q.size() == 0, q.size() == 16, mov);
    end
    vec++;
    if (rd_data !== hd) begin
      err++;
      $display("FAIL %s rd_data: got %h, required %h", name, rd_data, hd);
    end
  endtask

  // One rx_done pulse, optionally with a coincident pop and/or overrun clear.
  task automatic write_byte(input logic [7:0] d, input logic rd, input logic clr);
    logic accept;
    accept      = (q.size() < 16) || rd;
    rx_data     = d;
    rx_done     = 1'b1;
    rd_en       = rd;
    clr_overrun = clr;
    tick();
    rx_done     = 1'b0;
    rd_en       = 1'b0;
    clr_overrun = 1'b0;
    if (rd && q.size() != 0) void'(q.pop_front());
    if (accept) begin
      q.push_back(d);
      if (clr) mov = 1'b0;
    end else begin
      mov = 1'b1;
    end
    check_status("write");
    tick();
  endtask

  task automatic pop();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
    check_status("pop");
  endtask

  task automatic test_reset();
    rst = 1'b0; rx_done = 1'b1; rx_data = 8'hE7; rd_en = 1'b0; clr_overrun = 1'b0;
    q.delete(); mov = 1'b0;
    repeat (3) tick();
    check_status("reset_hold");
    rst = 1'b1;
    repeat (4) tick();
    check_status("reset_release_rx_done_high");
    rx_done = 1'b0;
    tick();
    check_status("reset_idle");
  endtask

  task automatic test_single();
    rx_data = 8'hAA; rx_done = 1'b1;
    tick();
    q.push_back(8'hAA);
    check_status("single_latency");
    repeat (49) tick();
    rx_done = 1'b0;
    tick();
    check_status("single_held");
    pop();
  endtask

  task automatic test_fill_order();
    for (int i = 0; i < 16; i++) write_byte(8'(i), 1'b0, 1'b0);
    vec++;
    if (full !== 1'b1 || count !== 5'd16) begin
      err++;
      $display("FAIL fill: got full=%b count=%0d, required full=1 count=16", full, count);
    end
    for (int i = 0; i < 16; i++) pop();
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 16; i++) write_byte(8'(i), 1'b0, 1'b0);
    write_byte(8'h55, 1'b0, 1'b0);
    vec++;
    if (overrun !== 1'b1 || rd_data !== 8'h00) begin
      err++;
      $display("FAIL overrun_drop: got ovr=%b head=%h, required ovr=1 head=00", overrun, rd_data);
    end
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    mov = 1'b0;
    check_status("overrun_clear");
    write_byte(8'h56, 1'b0, 1'b1);
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    mov = 1'b0;
    check_status("overrun_clear2");
  endtask

  task automatic test_full_rdwr();
    write_byte(8'h77, 1'b1, 1'b0);
    vec++;
    if (rd_data !== 8'h01 || count !== 5'd16 || overrun !== 1'b0) begin
      err++;
      $display("FAIL full_rdwr: got head=%h count=%0d ovr=%b, required head=01 count=16 ovr=0",
               rd_data, count, overrun);
    end
    while (q.size() != 0) pop();
  endtask

  task automatic test_wrap();
    pop();
    write_byte(8'hC0, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) begin
      write_byte(8'($urandom_range(0, 255)), 1'b0, 1'b0);
      if (q.size() >= 5 || (q.size() > 1 && $urandom_range(0, 1) == 1)) pop();
      if (q.size() >= 5) pop();
    end
    while (q.size() != 0) pop();
    pop();
    pop();
  endtask

  task automatic test_reset_midop();
    write_byte(8'h11, 1'b0, 1'b0);
    write_byte(8'h22, 1'b0, 1'b0);
    write_byte(8'h55, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    q.delete(); mov = 1'b0;
    check_status("reset_async");
    tick();
    rst = 1'b1;
    tick();
    write_byte(8'h3C, 1'b0, 1'b0);
    pop();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_order();
    test_overrun();
    test_full_rdwr();
    test_wrap();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
